// File: rtl/tlight.sv
`default_nettype none
// ============================================================================
// Module   : tlight
// Purpose  : Two-road traffic-light controller for a north-south (NS) and a
//            west-east (WE) road. A Moore FSM with a dwell-time counter hands
//            right-of-way back and forth between the two roads:
//              WE_READY_TO_GO -> WE_GO -> WE_PREPARE_TO_STOP ->
//              NS_READY_TO_GO -> NS_GO -> NS_PREPARE_TO_STOP -> (repeat)
// Ports    : clock  - single clock, all state changes on the rising edge
//            reset  - synchronous, active-high reset
//            ns     - NS lamp pattern (one-hot RED/YELLOW/GREEN)
//            we     - WE lamp pattern (one-hot RED/YELLOW/GREEN)
// Params   : READY_CYCLES, GO_CYCLES, STOP_CYCLES - dwell of each phase, >= 1
// Revision : 1.0 - initial release
// ============================================================================
module tlight #(
  parameter int READY_CYCLES = 3,
  parameter int GO_CYCLES    = 15,
  parameter int STOP_CYCLES  = 1
) (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] ns,
  output logic [2:0] we
);

  // Lamp encodings, one-hot
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    RESET              = 3'd0,
    WE_READY_TO_GO     = 3'd1,
    WE_GO              = 3'd2,
    WE_PREPARE_TO_STOP = 3'd3,
    NS_READY_TO_GO     = 3'd4,
    NS_GO              = 3'd5,
    NS_PREPARE_TO_STOP = 3'd6
  } state_t;

  // Counter only ever has to reach (longest dwell - 1) before the state
  // exits and the counter is cleared, so it never wraps inside a state.
  localparam int MAX_RG     = (READY_CYCLES > GO_CYCLES) ? READY_CYCLES : GO_CYCLES;
  localparam int MAX_CYCLES = (MAX_RG > STOP_CYCLES) ? MAX_RG : STOP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GO_LAST    = CNT_W'(GO_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_CYCLES - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic ready_done;
  logic go_done;
  logic stop_done;

  assign ready_done = (cnt_q == READY_LAST);
  assign go_done    = (cnt_q == GO_LAST);
  assign stop_done  = (cnt_q == STOP_LAST);

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      RESET:              state_d = WE_READY_TO_GO;
      WE_READY_TO_GO:     if (ready_done) state_d = WE_GO;
      WE_GO:              if (go_done)    state_d = WE_PREPARE_TO_STOP;
      WE_PREPARE_TO_STOP: if (stop_done)  state_d = NS_READY_TO_GO;
      NS_READY_TO_GO:     if (ready_done) state_d = NS_GO;
      NS_GO:              if (go_done)    state_d = NS_PREPARE_TO_STOP;
      NS_PREPARE_TO_STOP: if (stop_done)  state_d = WE_READY_TO_GO;
      default:            state_d = RESET;
    endcase
  end

  // Dwell counter restarts from zero on every state entry
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Moore output decode from the registered state only
  always_comb begin
    ns = RED;
    we = RED;
    case (state)
      WE_READY_TO_GO:     we = YELLOW;
      WE_GO:              we = GREEN;
      WE_PREPARE_TO_STOP: we = YELLOW;
      NS_READY_TO_GO:     ns = YELLOW;
      NS_GO:              ns = GREEN;
      NS_PREPARE_TO_STOP: ns = YELLOW;
      default: begin
        ns = RED;
        we = RED;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tlight.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlight
// Purpose  : Self-checking bench for tlight. Expected lamp patterns come from
//            the elapsed-cycle count since the last reset edge, mapped onto
//            the phase schedule with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlight;

  localparam int READY = 3;
  localparam int GO    = 15;
  localparam int STOP  = 1;
  localparam int PERIOD = 2 * (READY + GO + STOP);

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  logic       clock;
  logic       reset;
  logic [2:0] ns;
  logic [2:0] we;

  int n_checks = 0;
  int n_fail   = 0;

  tlight #(
    .READY_CYCLES(READY),
    .GO_CYCLES   (GO),
    .STOP_CYCLES (STOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ns   (ns),
    .we   (we)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected lamps for a given number of non-reset edges since reset.
  // age 0 is the single RESET cycle; afterwards the 38-cycle schedule runs.
  function automatic void model(input int age, output logic [2:0] e_ns, output logic [2:0] e_we);
    int p;
    e_ns = L_RED;
    e_we = L_RED;
    if (age > 0) begin
      p = (age - 1) % PERIOD;
      if      (p < READY)                      e_we = L_YELLOW;
      else if (p < READY + GO)                 e_we = L_GREEN;
      else if (p < READY + GO + STOP)          e_we = L_YELLOW;
      else if (p < 2 * READY + GO + STOP)      e_ns = L_YELLOW;
      else if (p < 2 * READY + 2 * GO + STOP)  e_ns = L_GREEN;
      else                                     e_ns = L_YELLOW;
    end
  endfunction

  initial begin
    int          age;
    bit          valid;
    logic [2:0]  e_ns;
    logic [2:0]  e_we;
    int          n_cycles;

    age      = 0;
    valid    = 1'b0;
    reset    = 1'b1;
    n_cycles = 480;

    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      @(posedge clock);
      if (reset) begin
        age   = 0;
        valid = 1'b1;
      end else if (valid) begin
        age++;
      end

      @(negedge clock);
      if (valid) begin
        model(age, e_ns, e_we);
        check($sformatf("ns@age%0d", age), 32'(ns), 32'(e_ns));
        check($sformatf("we@age%0d", age), 32'(we), 32'(e_we));
        check("ns_onehot", 32'($onehot(ns)), 32'd1);
        check("we_onehot", 32'($onehot(we)), 32'd1);
        check("both_not_red", 32'((ns != L_RED) && (we != L_RED)), 32'd0);
      end

      // Stimulus: one-cycle reset at start, one mid-NS_GO reset at cycle 30
      // (29 edges into the sequence), a clean run, then random resets.
      if (cyc == 29)       reset = 1'b1;
      else if (cyc < 160)  reset = 1'b0;
      else                 reset = ($urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
